// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - lock/soft-reset inputs and staged reset outputs of the reset sequencer
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  hold_n;
  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  seq_done;
  logic                  busy;

  // Controller side: supplies lock/soft-reset and observes the domain resets
  modport master (
    output hold_n,
    output soft_rst_req,
    input  stage_rst_n,
    input  seq_done,
    input  busy
  );

  // Sequencer side
  modport slave (
    input  hold_n,
    input  soft_rst_req,
    output stage_rst_n,
    output seq_done,
    output busy
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged per-domain reset release with soft-reset and loss-of-lock re-sequencing
module reset_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_DLY  = 16,
  parameter int SOFT_MIN   = 8,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  reset_sequencer_if.slave   seq_if
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_MIN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    DELAY     = 2'd1,
    RUN       = 2'd2,
    SOFT      = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  seq_done_q, seq_done_d;
  logic                  busy_q, busy_d;
  logic                  abort;
  logic                  go_soft;

  // Loss of lock and a soft request are treated identically
  assign abort = seq_if.soft_rst_req || !seq_if.hold_n;

  // State and output registers; reset forces all domains back into reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      idx_q      <= '0;
      stage_q    <= '0;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stage_q    <= stage_d;
      seq_done_q <= seq_done_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: release one stage per delay period, abort wins over a release on the same edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stage_d    = stage_q;
    seq_done_d = seq_done_q;
    busy_d     = busy_q;
    go_soft    = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        if (seq_if.hold_n) begin
          state_d = DELAY;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      DELAY: begin
        if (abort) begin
          go_soft = 1'b1;
        end else if (cnt_q == DLY_LAST) begin
          // Releasing by index on top of the held bits keeps the code thermometer
          stage_d[idx_q] = 1'b1;
          cnt_d          = '0;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d    = RUN;
            seq_done_d = 1'b1;
            busy_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          go_soft = 1'b1;
        end
      end
      SOFT: begin
        // Fixed-length hold; inputs are deliberately not looked at here
        if (cnt_q == SOFT_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        idx_d   = '0;
        stage_d = '0;
      end
    endcase

    if (go_soft) begin
      state_d    = SOFT;
      cnt_d      = '0;
      idx_d      = '0;
      stage_d    = '0;
      seq_done_d = 1'b0;
      busy_d     = 1'b1;
    end
  end

  assign seq_if.stage_rst_n = stage_q;
  assign seq_if.seq_done    = seq_done_q;
  assign seq_if.busy        = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer release timing, aborts and async reset
module tb_reset_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  reset_sequencer_if #(.NUM_STAGES(3)) sif ();

  reset_sequencer #(
    .NUM_STAGES(3),
    .STAGE_DLY (16),
    .SOFT_MIN  (8),
    .CNT_W     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq_if(sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge number N, cyc reads N at the following negedge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, logic [2:0] st, logic d, logic b);
    exp_t e;
    e.cyc  = c;
    e.st   = st;
    e.done = d;
    e.busy = b;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    rst_n            = 1'b0;
    sif.hold_n       = 1'b0;
    sif.soft_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sif.stage_rst_n !== 3'b000) begin
      failures++;
      $display("FAIL reset_stage got=%b exp=000", sif.stage_rst_n);
    end
    checks++;
    if (sif.seq_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", sif.seq_done);
    end
    checks++;
    if (sif.busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=1", sif.busy);
    end
  endtask

  task automatic test_power_up();
    int e0;
    exp_t e;
    sif.hold_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    push(e0,      3'b000, 1'b0, 1'b1);
    push(e0 + 15, 3'b000, 1'b0, 1'b1);
    push(e0 + 16, 3'b001, 1'b0, 1'b1);
    push(e0 + 31, 3'b001, 1'b0, 1'b1);
    push(e0 + 32, 3'b011, 1'b0, 1'b1);
    push(e0 + 47, 3'b011, 1'b0, 1'b1);
    push(e0 + 48, 3'b111, 1'b1, 1'b0);
    push(e0 + 50, 3'b111, 1'b1, 1'b0);
    for (int n = 0; n < 100 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {sif.stage_rst_n, sif.seq_done, sif.busy} !== {e.st, e.done, e.busy}) begin
          failures++;
          $display("FAIL power_up cyc=%0d got stage=%b done=%b busy=%b exp stage=%b done=%b busy=%b at cyc=%0d",
                   cyc, sif.stage_rst_n, sif.seq_done, sif.busy, e.st, e.done, e.busy, e.cyc);
        end
      end
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL power_up timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_hold_low();
    int c;
    exp_t e;
    @(negedge clk);
    rst_n      = 1'b0;
    sif.hold_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    push(c + 1,         3'b000, 1'b0, 1'b1);
    push(c + 50,        3'b000, 1'b0, 1'b1);
    push(c + 100,       3'b000, 1'b0, 1'b1);
    push(c + 101 + 15,  3'b000, 1'b0, 1'b1);
    push(c + 101 + 16,  3'b001, 1'b0, 1'b1);
    push(c + 101 + 32,  3'b011, 1'b0, 1'b1);
    push(c + 101 + 48,  3'b111, 1'b1, 1'b0);
    for (int n = 0; n < 250 && sb.size() > 0; n++) begin
      @(negedge clk);
      if (cyc == c + 100) sif.hold_n = 1'b1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {sif.stage_rst_n, sif.seq_done, sif.busy} !== {e.st, e.done, e.busy}) begin
          failures++;
          $display("FAIL hold_low cyc=%0d got stage=%b done=%b busy=%b exp stage=%b done=%b busy=%b at cyc=%0d",
                   cyc, sif.stage_rst_n, sif.seq_done, sif.busy, e.st, e.done, e.busy, e.cyc);
        end
      end
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL hold_low timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_soft();
    int s;
    exp_t e;
    @(negedge clk);
    sif.soft_rst_req = 1'b1;
    s = cyc + 1;
    push(s,      3'b000, 1'b0, 1'b1);
    push(s + 7,  3'b000, 1'b0, 1'b1);
    push(s + 8,  3'b000, 1'b0, 1'b1);
    push(s + 24, 3'b000, 1'b0, 1'b1);
    push(s + 25, 3'b001, 1'b0, 1'b1);
    push(s + 40, 3'b001, 1'b0, 1'b1);
    push(s + 41, 3'b011, 1'b0, 1'b1);
    push(s + 56, 3'b011, 1'b0, 1'b1);
    push(s + 57, 3'b111, 1'b1, 1'b0);
    for (int n = 0; n < 100 && sb.size() > 0; n++) begin
      @(negedge clk);
      if (cyc == s) sif.soft_rst_req = 1'b0;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {sif.stage_rst_n, sif.seq_done, sif.busy} !== {e.st, e.done, e.busy}) begin
          failures++;
          $display("FAIL soft cyc=%0d got stage=%b done=%b busy=%b exp stage=%b done=%b busy=%b at cyc=%0d",
                   cyc, sif.stage_rst_n, sif.seq_done, sif.busy, e.st, e.done, e.busy, e.cyc);
        end
      end
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL soft timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_hold_drop();
    int e0;
    int e1;
    exp_t e;
    @(negedge clk);
    rst_n      = 1'b0;
    sif.hold_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    e0 = cyc + 1;
    e1 = e0 + 41;
    push(e0 + 16, 3'b001, 1'b0, 1'b1);
    push(e0 + 19, 3'b001, 1'b0, 1'b1);
    push(e0 + 20, 3'b000, 1'b0, 1'b1);
    push(e0 + 27, 3'b000, 1'b0, 1'b1);
    push(e0 + 28, 3'b000, 1'b0, 1'b1);
    push(e0 + 40, 3'b000, 1'b0, 1'b1);
    push(e1 + 15, 3'b000, 1'b0, 1'b1);
    push(e1 + 16, 3'b001, 1'b0, 1'b1);
    push(e1 + 31, 3'b001, 1'b0, 1'b1);
    push(e1 + 32, 3'b000, 1'b0, 1'b1);
    push(e1 + 50, 3'b000, 1'b0, 1'b1);
    push(e1 + 51 + 16, 3'b001, 1'b0, 1'b1);
    push(e1 + 51 + 48, 3'b111, 1'b1, 1'b0);
    for (int n = 0; n < 300 && sb.size() > 0; n++) begin
      @(negedge clk);
      if (cyc == e0 + 19) sif.hold_n = 1'b0;
      if (cyc == e0 + 40) sif.hold_n = 1'b1;
      if (cyc == e1 + 31) sif.hold_n = 1'b0;
      if (cyc == e1 + 50) sif.hold_n = 1'b1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {sif.stage_rst_n, sif.seq_done, sif.busy} !== {e.st, e.done, e.busy}) begin
          failures++;
          $display("FAIL hold_drop cyc=%0d got stage=%b done=%b busy=%b exp stage=%b done=%b busy=%b at cyc=%0d",
                   cyc, sif.stage_rst_n, sif.seq_done, sif.busy, e.st, e.done, e.busy, e.cyc);
        end
      end
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL hold_drop timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_reset();
    int e0;
    exp_t e;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sif.stage_rst_n, sif.seq_done, sif.busy} !== 5'b000_0_1) begin
      failures++;
      $display("FAIL async_assert got stage=%b done=%b busy=%b exp stage=000 done=0 busy=1",
               sif.stage_rst_n, sif.seq_done, sif.busy);
    end
    sif.hold_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sif.stage_rst_n, sif.seq_done, sif.busy} !== 5'b000_0_1) begin
      failures++;
      $display("FAIL async_hold got stage=%b done=%b busy=%b exp stage=000 done=0 busy=1",
               sif.stage_rst_n, sif.seq_done, sif.busy);
    end
    rst_n = 1'b1;
    e0 = cyc + 1;
    push(e0 + 15, 3'b000, 1'b0, 1'b1);
    push(e0 + 16, 3'b001, 1'b0, 1'b1);
    push(e0 + 32, 3'b011, 1'b0, 1'b1);
    push(e0 + 48, 3'b111, 1'b1, 1'b0);
    for (int n = 0; n < 100 && sb.size() > 0; n++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {sif.stage_rst_n, sif.seq_done, sif.busy} !== {e.st, e.done, e.busy}) begin
          failures++;
          $display("FAIL async_resume cyc=%0d got stage=%b done=%b busy=%b exp stage=%b done=%b busy=%b at cyc=%0d",
                   cyc, sif.stage_rst_n, sif.seq_done, sif.busy, e.st, e.done, e.busy, e.cyc);
        end
      end
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL async_resume timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_ignore();
    int c;
    int s;
    exp_t e;
    @(negedge clk);
    rst_n      = 1'b0;
    sif.hold_n = 1'b0;
    @(negedge clk);
    rst_n            = 1'b1;
    sif.soft_rst_req = 1'b1;
    c = cyc;
    push(c + 1,      3'b000, 1'b0, 1'b1);
    push(c + 6,      3'b000, 1'b0, 1'b1);
    push(c + 7 + 16, 3'b001, 1'b0, 1'b1);
    push(c + 7 + 48, 3'b111, 1'b1, 1'b0);
    for (int n = 0; n < 100 && sb.size() > 0; n++) begin
      @(negedge clk);
      if (cyc == c + 5) sif.soft_rst_req = 1'b0;
      if (cyc == c + 6) sif.hold_n = 1'b1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {sif.stage_rst_n, sif.seq_done, sif.busy} !== {e.st, e.done, e.busy}) begin
          failures++;
          $display("FAIL ignore_wait cyc=%0d got stage=%b done=%b busy=%b exp stage=%b done=%b busy=%b at cyc=%0d",
                   cyc, sif.stage_rst_n, sif.seq_done, sif.busy, e.st, e.done, e.busy, e.cyc);
        end
      end
    end
    @(negedge clk);
    sif.soft_rst_req = 1'b1;
    s = cyc + 1;
    push(s,      3'b000, 1'b0, 1'b1);
    push(s + 7,  3'b000, 1'b0, 1'b1);
    push(s + 8,  3'b000, 1'b0, 1'b1);
    push(s + 24, 3'b000, 1'b0, 1'b1);
    push(s + 25, 3'b001, 1'b0, 1'b1);
    for (int n = 0; n < 100 && sb.size() > 0; n++) begin
      @(negedge clk);
      if (cyc == s + 3) sif.soft_rst_req = 1'b0;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || {sif.stage_rst_n, sif.seq_done, sif.busy} !== {e.st, e.done, e.busy}) begin
          failures++;
          $display("FAIL ignore_soft cyc=%0d got stage=%b done=%b busy=%b exp stage=%b done=%b busy=%b at cyc=%0d",
                   cyc, sif.stage_rst_n, sif.seq_done, sif.busy, e.st, e.done, e.busy, e.cyc);
        end
      end
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL ignore timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    test_reset();
    test_power_up();
    test_hold_low();
    test_soft();
    test_hold_drop();
    test_async_reset();
    test_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Multi-domain reset release controller for the DE0-nano design. It consumes the already-synchronized system reset and a lock/ready qualifier such as PLL locked. It releases per-subsystem active-low resets one stage at a time, with a fixed spacing between stages. It also handles soft-reset requests and loss of lock by re-asserting every stage and re-running the sequence.

Parameters:
NUM_STAGES, 3, number of reset domains sequenced; stage 0 is released first. Legal range is 1 or more.
STAGE_DLY, 16, clock cycles between sequence start and the stage 0 release, and between successive stage releases. Legal range is 1 or more.
SOFT_MIN, 8, number of cycles all stages are held in reset after a soft reset or loss of lock. Legal range is 1 or more.
CNT_W, 8, delay counter width. Must satisfy 2^CNT_W > max(STAGE_DLY, SOFT_MIN).

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  active-low asynchronous reset, already synchronized (deasserts cleanly).
hold_n  input  1  lock qualifier; low means "not ready"; synchronous to clk.
soft_rst_req  input  1  synchronous request, sampled on posedge; 1 cycle wide or longer.
stage_rst_n  output  NUM_STAGES  per-domain active-low resets; registered; thermometer coded.
seq_done  output  1  high only in RUN, meaning every stage is released; registered.
busy  output  1  high whenever the state is not RUN; registered.

Behaviour:
Clock and reset:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- rst_n low forces, immediately and without a clock edge: state WAIT_LOCK, counter 0, stage index 0, stage_rst_n all 0, seq_done 0, busy 1.

States:
- WAIT_LOCK: hold at the current outputs (all stages in reset). On the first posedge with hold_n=1 (edge E0), go to DELAY with counter 0 and index 0. soft_rst_req is ignored here.
- DELAY: counter increments every edge.
  - On the edge where the pre-edge counter equals STAGE_DLY-1: set stage_rst_n[index] to 1, clear counter, increment index.
  - If the stage just released was NUM_STAGES-1, go to RUN and set seq_done=1 and busy=0 on that same edge.
  - Timing: stage k releases at edge E0+(k+1)*STAGE_DLY.
- RUN: outputs hold.
  - soft_rst_req=1 or hold_n=0 at an edge: go to SOFT.
- SOFT: entered at edge S.
  - From edge S: stage_rst_n all 0, seq_done 0, busy 1, counter 0, index 0.
  - Stay exactly SOFT_MIN cycles; WAIT_LOCK is entered at edge S+SOFT_MIN.
  - soft_rst_req and hold_n are ignored in SOFT; the period is not extended.

Boundary and simultaneous-event rules:
- hold_n=0 at any DELAY edge, including the release edge: go to SOFT; released stages re-assert at that edge and no release occurs.
- soft_rst_req=1 during DELAY: same as hold_n=0 (go to SOFT).
- soft_rst_req and hold_n=0 on the same edge: a single SOFT entry.
- stage_rst_n is always a thermometer code (bit k=1 implies all bits below k are 1). Releases are never out of order and never partial-deasserted.
- STAGE_DLY=1: stages release on consecutive edges, E0+1, E0+2, and so on.
- NUM_STAGES=1: seq_done rises together with stage 0.
- Counter never wraps: it is cleared on every release and on every state change.
- No combinational path from any input to any output.

Test Plan:
Defaults are NUM_STAGES=3, STAGE_DLY=16, SOFT_MIN=8.
1. Power-up, hold_n=1 throughout: rst_n rises, first posedge is E0 -> stage_rst_n=000 until E0+16, then 001; 011 at E0+32; 111 with seq_done=1 and busy=0 at E0+48.
2. hold_n=0 for 100 cycles after rst_n rises -> stage_rst_n stays 000 and busy=1. hold_n rises and is first sampled at E0 -> scenario 1 timing relative to E0.
3. RUN, 1-cycle soft_rst_req sampled at edge S -> from S: 000, seq_done=0, busy=1. WAIT_LOCK at S+8; with hold_n=1, 001 at S+25, 011 at S+41, 111 at S+57.
4. hold_n drops so that its first low sample is at E0+20 (stage_rst_n=001) -> 000 at E0+20. No further releases until SOFT_MIN cycles later and a new hold_n=1 sample; then the sequence restarts from stage 0.
5. rst_n pulled low mid-RUN between clock edges -> stage_rst_n=000, seq_done=0, busy=1 asynchronously. Held low for 5 edges, no state change. rst_n released -> scenario 1 timing.
6. soft_rst_req=1 in WAIT_LOCK with hold_n=0 -> no effect. soft_rst_req=1 for 4 cycles during SOFT -> WAIT_LOCK is still entered exactly at S+8.
